// File: rtl/multi_debouncer_pkg.sv
// rtl/multi_debouncer_pkg.sv - shared repeat-FSM encoding and default widths
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_PER = 2'd2
  } rpt_state_t;

  localparam int DEF_CNT_W     = 16;
  localparam int DEF_RPT_DLY_W = 24;

endpackage

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - one button: synchroniser, stability counter, auto-repeat FSM
module debounce_ch
  import multi_debouncer_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int RPT_DLY_W  = DEF_RPT_DLY_W,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 raw,
  input  logic                 rpt_en,
  input  logic [RPT_DLY_W-1:0] rpt_dly,
  input  logic [RPT_DLY_W-1:0] rpt_per,
  output logic                 state,
  output logic                 down,
  output logic                 up,
  output logic                 rpt
);

  localparam logic [RPT_DLY_W-1:0] R_ONE = RPT_DLY_W'(1);

  logic                 in_lvl;
  logic                 sync1;
  logic                 sample;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 press_evt;
  logic                 rel_evt;
  logic [RPT_DLY_W-1:0] dly_eff;
  logic [RPT_DLY_W-1:0] per_eff;
  rpt_state_t           rs;
  rpt_state_t           rs_nx;
  logic [RPT_DLY_W-1:0] rcnt;
  logic [RPT_DLY_W-1:0] rcnt_nx;
  logic                 rpt_nx;

  assign in_lvl    = (ACTIVE_LOW != 0) ? ~raw : raw;
  assign accept    = (sample != state) && (&cnt);
  assign press_evt = accept && !state;
  assign rel_evt   = accept && state;
  // A zero delay/period behaves as one so the repeat counter never stalls at 0
  assign dly_eff   = (rpt_dly == '0) ? R_ONE : rpt_dly;
  assign per_eff   = (rpt_per == '0) ? R_ONE : rpt_per;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b0;
      sample <= 1'b0;
      state  <= 1'b0;
      cnt    <= '0;
      down   <= 1'b0;
      up     <= 1'b0;
    end else begin
      sync1  <= in_lvl;
      sample <= sync1;
      down   <= press_evt;
      up     <= rel_evt;
      if (sample == state) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        state <= ~state;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs   <= IDLE;
      rcnt <= '0;
      rpt  <= 1'b0;
    end else begin
      rs   <= rs_nx;
      rcnt <= rcnt_nx;
      rpt  <= rpt_nx;
    end
  end

  always_comb begin
    rs_nx   = rs;
    rcnt_nx = rcnt;
    rpt_nx  = 1'b0;
    if (rel_evt) begin
      rs_nx   = IDLE;
      rcnt_nx = '0;
    end else begin
      case (rs)
        IDLE: begin
          if (press_evt) begin
            rs_nx   = HOLD_DLY;
            rcnt_nx = dly_eff;
            rpt_nx  = 1'b1;
          end
        end
        HOLD_DLY, HOLD_PER: begin
          // Parks at 1 while repeat is disabled, firing as soon as it is enabled
          if (rcnt == R_ONE) begin
            if (rpt_en) begin
              rpt_nx  = 1'b1;
              rcnt_nx = per_eff;
              rs_nx   = HOLD_PER;
            end
          end else begin
            rcnt_nx = rcnt - R_ONE;
          end
        end
        default: begin
          rs_nx   = IDLE;
          rcnt_nx = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// rtl/multi_debouncer.sv - NUM_CH independent debounced buttons with auto-repeat
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ACTIVE_LOW = 1,
  parameter int RPT_DLY_W  = DEF_RPT_DLY_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH-1:0]    btn_raw,
  input  logic [NUM_CH-1:0]    rpt_en,
  input  logic [RPT_DLY_W-1:0] rpt_dly,
  input  logic [RPT_DLY_W-1:0] rpt_per,
  output logic [NUM_CH-1:0]    btn_state,
  output logic [NUM_CH-1:0]    btn_down,
  output logic [NUM_CH-1:0]    btn_up,
  output logic [NUM_CH-1:0]    btn_rpt,
  output logic                 any_down
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_ch #(
      .CNT_W      (CNT_W),
      .RPT_DLY_W  (RPT_DLY_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw     (btn_raw[i]),
      .rpt_en  (rpt_en[i]),
      .rpt_dly (rpt_dly),
      .rpt_per (rpt_per),
      .state   (btn_state[i]),
      .down    (btn_down[i]),
      .up      (btn_up[i]),
      .rpt     (btn_rpt[i])
    );
  end

  assign any_down = |btn_down;

endmodule
